// File: rtl/dsi_cmd_sched.sv
// DSI short-command scheduler: queues commands, issues at most one header per blank line via dsi_ecc.
// pkt_valid rises 3 cycles after the slot; optional coalescing is enabled by the DSI_CMD_COALESCE_EN macro.
module dsi_cmd_sched #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MAX_PER_FRAME = 8,
  parameter logic [1:0]  VC            = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        hsync,
  input  logic        active,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_dt,
  input  logic [15:0] cmd_data,
  output logic [23:0] ecc_in,
  input  logic [31:0] ecc_out,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [31:0] pkt_hdr,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ECC, CAP, OFFER} state_t;

  logic [5:0]    dt_q [DEPTH];
  logic [7:0]    d0_q [DEPTH];
  logic [7:0]    d1_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hsync_q, vsync_q;
  logic          blank_line_q, blank_line_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  state_t        state_q;
  logic [23:0]   ecc_in_q;
  logic [31:0]   pkt_hdr_q;
  logic          pkt_valid_q;

  logic full, empty, hsync_rise, vsync_rise, slot, cap_ok, pop, push;

  assign full       = (cnt_q == CW'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign hsync_rise = hsync & ~hsync_q;
  assign vsync_rise = vsync & ~vsync_q;
  assign slot       = hsync_rise & blank_line_q;
  assign cap_ok     = (frame_cnt_q < 8'(MAX_PER_FRAME));
  assign pop        = (state_q == IDLE) & slot & ~empty & cap_ok;

`ifdef DSI_CMD_COALESCE_EN
  logic          hit;
  logic [AW-1:0] hit_idx;

  // Scan oldest to youngest so the youngest matching live entry wins; the head being popped is excluded.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < cnt_q) && !(pop && (k == 0)) &&
          (dt_q[rd_ptr_q + AW'(k)] == cmd_dt) &&
          (d0_q[rd_ptr_q + AW'(k)] == cmd_data[7:0])) begin
        hit     = 1'b1;
        hit_idx = rd_ptr_q + AW'(k);
      end
    end
  end

  assign cmd_ready = ~full | hit;
  assign push      = cmd_valid & cmd_ready & ~hit;
`else
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    blank_line_d = blank_line_q;
    if (active)
      blank_line_d = 1'b0;
    else if (hsync_rise)
      blank_line_d = 1'b1;
    frame_cnt_d = frame_cnt_q;
    if (vsync_rise)
      frame_cnt_d = pop ? 8'd1 : 8'd0;
    else if (pop)
      frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dt_q[wr_ptr_q] <= cmd_dt;
      d0_q[wr_ptr_q] <= cmd_data[7:0];
      d1_q[wr_ptr_q] <= cmd_data[15:8];
    end
`ifdef DSI_CMD_COALESCE_EN
    if (cmd_valid && hit)
      d1_q[hit_idx] <= cmd_data[15:8];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      blank_line_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      hsync_q      <= hsync;
      vsync_q      <= vsync;
      blank_line_q <= blank_line_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // ecc_in is held through ECC so the external dsi_ecc result is ready to capture in CAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ecc_in_q    <= '0;
      pkt_hdr_q   <= '0;
      pkt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            ecc_in_q <= {VC, dt_q[rd_ptr_q], d0_q[rd_ptr_q], d1_q[rd_ptr_q]};
            state_q  <= ECC;
          end
        end
        ECC: state_q <= CAP;
        CAP: begin
          pkt_hdr_q   <= ecc_out;
          pkt_valid_q <= 1'b1;
          state_q     <= OFFER;
        end
        OFFER: begin
          if (pkt_ready) begin
            pkt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ecc_in    = ecc_in_q;
  assign pkt_hdr   = pkt_hdr_q;
  assign pkt_valid = pkt_valid_q;
  assign busy      = ~empty | (state_q != IDLE);

endmodule
